mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
Moore state machine that sequences the shared ALU, register file, memory and PC of the multi-cycle MIPS datapath, one instruction at a time. It decodes the IR opcode (and funct for JR) and drives every mux select and write enable. It also produces the 3-bit ALUOp class code consumed by the ALU control decoder. It sits beside the instruction register and replaces the single-cycle combinational control unit.

Parameters:
STATE_WIDTH, 4, width of state register and State debug output (14 states used, codes 0-13)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Opcode  input  6  IR[31:26]; valid from DECODE onward
Funct  input  6  IR[5:0]; valid from DECODE onward
Zero  input  1  ALU zero flag, combinational from current ALU inputs
PCWrite  output  1  PC load enable (branch condition already folded in)
IorD  output  1  memory address select: 0 PC, 1 ALUOut
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load
RegWrite  output  1  register file write enable
RegDst  output  2  write reg: 00 rt, 01 rd, 10 $31
MemtoReg  output  2  write data: 00 ALUOut, 01 MDR, 10 PC
ALUSrcA  output  1  0 PC, 1 register A
ALUSrcB  output  2  00 register B, 01 constant 4, 10 extended imm, 11 imm<<2
ExtSel  output  1  0 sign-extend, 1 zero-extend immediate
ALUOp  output  3  111 R-type, 100 add, 101 or, 110 and, 001 subtract (branch)
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A (JR)
State  output  STATE_WIDTH  current state, for debug/verification

Behaviour:
- States: 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_RD, 4 MEM_WB, 5 MEM_WR, 6 EXEC_R, 7 R_WB, 8 EXEC_I, 9 I_WB, 10 BRANCH, 11 JUMP, 12 JAL, 13 JR.
- Reset low: State=FETCH immediately (async). PCWrite, IRWrite, MemRead, MemWrite, RegWrite forced 0 while reset is low. All other outputs take their FETCH values.
- Output defaults in every state: enables 0, selects 0, ALUOp 100, ExtSel 0. Each state overrides only the signals listed below.
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcB=11 (branch target into ALUOut). Opcode and Funct are registered internally on this edge; later states use the registered copies.
- DECODE transitions:
  - 000000 with funct 001000 -> JR; 000000 otherwise -> EXEC_R
  - 100011/101011 -> MEM_ADDR
  - 001000/001100/001101 -> EXEC_I
  - 000100/000101 -> BRANCH
  - 000010 -> JUMP; 000011 -> JAL
  - any other opcode -> FETCH (executes as a no-op)
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10. Next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: IorD=1, MemRead=1, then MEM_WB. MEM_WB: RegWrite=1, MemtoReg=01, then FETCH.
- MEM_WR: IorD=1, MemWrite=1, then FETCH.
- EXEC_R: ALUSrcA=1, ALUOp=111, then R_WB. R_WB: RegWrite=1, RegDst=01, ALUOp=111, then FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, then I_WB.
  - ALUOp per opcode: ADDI 100, ANDI 110, ORI 101.
  - ExtSel=1 for ANDI/ORI.
- I_WB: RegWrite=1, RegDst=00, MemtoReg=00; ALUOp and ExtSel held from EXEC_I. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. PCWrite = Zero for BEQ, ~Zero for BNE. Next FETCH.
- JUMP: PCSource=10, PCWrite=1, then FETCH.
- JAL: PCSource=10, PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10, then FETCH. $31 receives the pre-edge PC (already PC+4).
- JR: PCSource=11, PCWrite=1, then FETCH.
- Latencies, FETCH to FETCH: LW 5 cycles; R, I-ALU, SW 4; BEQ/BNE/J/JAL/JR 3; unknown opcode 2.
- Unused state codes 14-15 -> FETCH next edge, all enables 0.
- Reset asserted mid-instruction: abort immediately, no partial writes after the asserting edge. Resume at FETCH on the first rising clk after release.

Test Plan:
- Hold reset low 3 cycles -> State=0, all enables 0. Release -> cycle 1: PCWrite=1, IRWrite=1, MemRead=1, ALUSrcB=01, ALUOp=100.
- Opcode 000000 Funct 100000 -> State 0,1,6,7,0. In state 7: RegWrite=1, RegDst=01, ALUOp=111.
- Opcode 100011 -> State 0,1,2,3,4,0. IorD=1 in 3; RegWrite=1 with MemtoReg=01 in 4. Repeat with 101011 -> 0,1,2,5,0 with MemWrite=1 in 5.
- Opcode 000100 with Zero=1, then Zero=0 -> PCWrite 1, then 0, in BRANCH. Opcode 000101 with the same Zero values -> PCWrite 0, then 1.
- Opcode 001101 -> EXEC_I/I_WB with ALUOp=101, ExtSel=1. Opcode 000011 -> JAL with RegDst=10, MemtoReg=10, PCWrite=1. Funct 001000 R-type -> JR with PCSource=11. Opcode 111111 -> 0,1,0.
- Assert reset in MEM_RD -> State=0 at once, MemRead=0, no RegWrite pulse. Release -> normal fetch.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute
// and drives every mux select and enable; PCWrite alone also depends on Zero in BRANCH.
module mips_multicycle_control #(
    parameter int STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             Opcode,
    input  logic [5:0]             Funct,
    input  logic                   Zero,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegWrite,
    output logic [1:0]             RegDst,
    output logic [1:0]             MemtoReg,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic                   ExtSel,
    output logic [2:0]             ALUOp,
    output logic [1:0]             PCSource,
    output logic [STATE_WIDTH-1:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;

    // Funct only matters on the decode edge (JR vs other R-type), so only the opcode is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d  = S_FETCH;
        op_d     = (state_q == S_DECODE) ? Opcode : op_q;
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ExtSel   = 1'b0;
        ALUOp    = 3'b100;
        PCSource = 2'b00;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_RTYPE:              state_d = (Funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW:          state_d = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI,
                    OP_ORI:                state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:        state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    OP_JAL:                state_d = S_JAL;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                ALUOp    = 3'b111;
            end
            S_EXEC_I, S_I_WB: begin
                // ALUOp/ExtSel stay stable into I_WB so ALUOut's source is unchanged.
                if (state_q == S_EXEC_I) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = S_I_WB;
                end else begin
                    RegWrite = 1'b1;
                end
                case (op_q)
                    OP_ANDI: begin ALUOp = 3'b110; ExtSel = 1'b1; end
                    OP_ORI:  begin ALUOp = 3'b101; ExtSel = 1'b1; end
                    default: begin ALUOp = 3'b100; ExtSel = 1'b0; end
                endcase
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b001;
                PCSource = 2'b01;
                PCWrite  = (op_q == OP_BNE) ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            S_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
            end
            S_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset forces state to FETCH asynchronously; only the write enables need masking.
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign State = STATE_WIDTH'(state_q);

endmodule
